regs_read_arbiter: RTL and testbench
====================================

# regs_read_arbiter

Round-robin arbiter that shares the single 4:1 register-select read port between four requesters. It accepts per-requester read requests carrying a 2-bit register index, drives the mux select, captures the mux result and returns it with a one-cycle acknowledge to the winning requester. It sits between the BPF execution/fetch units and the register read mux.

## Interface
- DATA_W, default 8: width of register data from the mux.
- iCLK  in  1  clock, all state on rising edge.
- inRST  in  1  asynchronous, active-low reset.
- iREQ  in  4  request per requester, bit i = requester i.
- iADDR  in  8  register index per requester; requester i uses iADDR[2i+1:2i].
- oSELECT  out  2  select driven to the register mux, registered.
- iMUX_DATA  in  DATA_W  mux result for the current oSELECT (combinational path through the mux).
- oACK  out  4  one-hot acknowledge pulse, bit i = requester i.
- oDATA  out  DATA_W  captured register value, valid while any oACK bit is high.
- oID  out  2  index of the requester being acknowledged.
- oBUSY  out  1  high in SEL and ACK states.

## Operation
- States: IDLE, SEL, ACK. Reset state IDLE.
- IDLE: if iREQ == 0, stay. Otherwise choose winner w = first set bit of iREQ scanning upward from pointer PTR with wrap (PTR, PTR+1, ... mod 4). At the edge: state <= SEL, grant register G <= w, oSELECT <= iADDR[2w+1:2w].
- SEL: mux settles on oSELECT. At the edge: oDATA <= iMUX_DATA, oACK <= one-hot(G), oID <= G, PTR <= (G+1) mod 4, state <= ACK.
- ACK: oACK/oDATA/oID presented for exactly this cycle. No arbitration in this state. At the edge: oACK <= 0, state <= IDLE. oDATA and oID hold their last value.
- Handshake: requester holds iREQ[i] high and iADDR slice stable from assertion until it sees oACK[i] high, then drops iREQ[i] at the next edge (at latest). A request still high in IDLE is a new request.
- iREQ[i] dropped before acknowledge (protocol violation): transaction already granted completes normally and is acknowledged; an ungranted dropped request is simply never served.
- iADDR changes after grant are ignored: oSELECT is latched in IDLE->SEL.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... starting from PTR; no requester waits more than 3 other grants.
- Reset (inRST low, any time, including mid-transaction): state IDLE, PTR 0, G 0, oSELECT 0, oACK 0, oDATA 0, oID 0, oBUSY 0. Transaction in flight is dropped without acknowledge; requesters re-request.

## Timing
- Request visible at edge N (state IDLE) -> oSELECT valid after edge N -> oACK/oDATA valid after edge N+1 for one cycle -> IDLE after edge N+2.
- Latency request-to-ack: 2 cycles; throughput: one grant per 3 cycles.
- oBUSY is combinational from state, high in SEL and ACK; all other outputs registered.
- iMUX_DATA sampled at end of SEL; mux plus routing must meet one clock period from oSELECT.
- Reset release: first arbitration at first rising edge with inRST high and iREQ != 0.

## Test plan
- Reset values: inRST low mid-SEL with iREQ=4'b0010 -> all outputs 0, state IDLE; after release, request served with PTR 0 ordering.
- Single request: mux regs {0x11,0x22,0x33,0x44}, iREQ=4'b0100, iADDR[5:4]=2 -> oSELECT=2 one cycle after, then oACK=4'b0100, oDATA=0x33, oID=2 for exactly one cycle.
- Round-robin: iREQ=4'b1111 held (each requester re-asserts after its ack), addresses 3,2,1,0 -> ack order 0,1,2,3,0 with data 0x44,0x33,0x22,0x11, 3 cycles apart.
- Pointer wrap: after grant to 3, iREQ=4'b1001 -> requester 0 wins; next grant 3.
- Address stability: change iADDR of granted requester during SEL -> oDATA reflects address latched at grant.
- Early drop: requester 1 granted then deasserts iREQ in SEL -> oACK=4'b0010 still issued with correct data; no second grant to 1.

Source files
------------

// File: rtl/regs_read_arbiter.sv
// Round-robin arbiter sharing one 4:1 register read mux among four requesters.
// Each grant runs IDLE -> SEL (mux settles) -> ACK (one-cycle acknowledge with captured data).
module regs_read_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              iCLK,
  input  logic              inRST,
  input  logic [3:0]        iREQ,
  input  logic [7:0]        iADDR,
  output logic [1:0]        oSELECT,
  input  logic [DATA_W-1:0] iMUX_DATA,
  output logic [3:0]        oACK,
  output logic [DATA_W-1:0] oDATA,
  output logic [1:0]        oID,
  output logic              oBUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_grant;
  logic [1:0]          r_select;
  logic [3:0]          r_ack;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_id;
  logic [1:0]          w_winner;

  // Scan from the highest offset down so the requester closest to ptr wins.
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    win = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

  assign w_winner = pick_winner(iREQ, r_ptr);

  // State register
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iREQ != 4'd0) begin
          w_next_state = ST_SEL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SEL:  w_next_state = ST_ACK;
      ST_ACK:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Grant, mux select, capture and acknowledge registers
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_ptr    <= 2'd0;
      r_grant  <= 2'd0;
      r_select <= 2'd0;
      r_ack    <= 4'd0;
      r_data   <= '0;
      r_id     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iREQ != 4'd0) begin
            r_grant  <= w_winner;
            r_select <= iADDR[{w_winner, 1'b0} +: 2];
          end
        end
        ST_SEL: begin
          r_data <= iMUX_DATA;
          r_ack  <= 4'b0001 << r_grant;
          r_id   <= r_grant;
          r_ptr  <= r_grant + 2'd1;
        end
        ST_ACK: begin
          // Data and id stay put; only the pulse ends.
          r_ack <= 4'd0;
        end
        default: begin
          r_ack <= 4'd0;
        end
      endcase
    end
  end

  assign oSELECT = r_select;
  assign oACK    = r_ack;
  assign oDATA   = r_data;
  assign oID     = r_id;
  assign oBUSY   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regs_read_arbiter.sv
// Bench for regs_read_arbiter: directed vector table, an async reset sequence,
// then random traffic compared against a transaction-level reference model.
module tb_regs_read_arbiter;

  logic       iCLK;
  logic       inRST;
  logic [3:0] iREQ;
  logic [7:0] iADDR;
  logic [1:0] oSELECT;
  logic [7:0] iMUX_DATA;
  logic [3:0] oACK;
  logic [7:0] oDATA;
  logic [1:0] oID;
  logic       oBUSY;

  logic [7:0] regs [4];
  int n_vec;
  int n_err;

  regs_read_arbiter #(.DATA_W(8)) dut (
    .iCLK(iCLK), .inRST(inRST), .iREQ(iREQ), .iADDR(iADDR),
    .oSELECT(oSELECT), .iMUX_DATA(iMUX_DATA), .oACK(oACK),
    .oDATA(oDATA), .oID(oID), .oBUSY(oBUSY)
  );

  assign iMUX_DATA = regs[oSELECT];

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [1:0] sel;
    logic [3:0] ack;
    logic [7:0] data;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(input logic [3:0] req, input logic [7:0] addr, input logic [1:0] sel,
                              input logic [3:0] ack, input logic [7:0] data, input logic [1:0] id,
                              input logic busy);
    vec_t v;
    v.req = req; v.addr = addr; v.sel = sel; v.ack = ack; v.data = data; v.id = id; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] esel, input logic [3:0] eack,
                       input logic [7:0] edata, input logic [1:0] eid, input logic ebusy);
    n_vec++;
    if (oSELECT !== esel || oACK !== eack || oDATA !== edata || oID !== eid || oBUSY !== ebusy) begin
      n_err++;
      $display("FAIL %s @%0t: got sel=%0d ack=%b data=%h id=%0d busy=%b, expected sel=%0d ack=%b data=%h id=%0d busy=%b",
               name, $time, oSELECT, oACK, oDATA, oID, oBUSY, esel, eack, edata, eid, ebusy);
    end
  endtask

  // Reference model: one transaction takes three edges; arbitration by rotating the request word.
  int         m_phase;
  int         m_ptr;
  int         m_g;
  logic [1:0] m_sel;
  logic [3:0] m_ack;
  logic [7:0] m_data;
  logic [1:0] m_id;

  task automatic m_reset();
    m_phase = 0; m_ptr = 0; m_g = 0; m_sel = 2'd0; m_ack = 4'd0; m_data = 8'd0; m_id = 2'd0;
  endtask

  task automatic m_edge(input logic [3:0] req, input logic [7:0] addr, input logic rst_n);
    logic [7:0] dbl;
    logic [3:0] rot;
    int j;
    if (!rst_n) begin
      m_reset();
    end else if (m_phase == 2) begin
      m_ack = 4'd0;
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_data = regs[m_sel];
      m_ack = 4'd1 << m_g;
      m_id = m_g[1:0];
      m_ptr = (m_g + 1) % 4;
      m_phase = 2;
    end else if (req != 4'd0) begin
      dbl = {req, req};
      rot = dbl[m_ptr +: 4];
      j = 0;
      while (!rot[j]) j++;
      m_g = (m_ptr + j) % 4;
      m_sel = addr[2*m_g +: 2];
      m_phase = 1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;

    // Round robin with addresses 3,2,1,0 for requesters 0..3
    for (int i = 0; i < 15; i++) tbl[i].req = 4'b1111;
    tbl[0]  = mk(4'b1111, 8'h1B, 2'd3, 4'b0000, 8'h00, 2'd0, 1'b1);
    tbl[1]  = mk(4'b1111, 8'h1B, 2'd3, 4'b0001, 8'h44, 2'd0, 1'b1);
    tbl[2]  = mk(4'b1111, 8'h1B, 2'd3, 4'b0000, 8'h44, 2'd0, 1'b0);
    tbl[3]  = mk(4'b1111, 8'h1B, 2'd2, 4'b0000, 8'h44, 2'd0, 1'b1);
    tbl[4]  = mk(4'b1111, 8'h1B, 2'd2, 4'b0010, 8'h33, 2'd1, 1'b1);
    tbl[5]  = mk(4'b1111, 8'h1B, 2'd2, 4'b0000, 8'h33, 2'd1, 1'b0);
    tbl[6]  = mk(4'b1111, 8'h1B, 2'd1, 4'b0000, 8'h33, 2'd1, 1'b1);
    tbl[7]  = mk(4'b1111, 8'h1B, 2'd1, 4'b0100, 8'h22, 2'd2, 1'b1);
    tbl[8]  = mk(4'b1111, 8'h1B, 2'd1, 4'b0000, 8'h22, 2'd2, 1'b0);
    tbl[9]  = mk(4'b1111, 8'h1B, 2'd0, 4'b0000, 8'h22, 2'd2, 1'b1);
    tbl[10] = mk(4'b1111, 8'h1B, 2'd0, 4'b1000, 8'h11, 2'd3, 1'b1);
    tbl[11] = mk(4'b1111, 8'h1B, 2'd0, 4'b0000, 8'h11, 2'd3, 1'b0);
    tbl[12] = mk(4'b1111, 8'h1B, 2'd3, 4'b0000, 8'h11, 2'd3, 1'b1);
    tbl[13] = mk(4'b1111, 8'h1B, 2'd3, 4'b0001, 8'h44, 2'd0, 1'b1);
    tbl[14] = mk(4'b1111, 8'h1B, 2'd3, 4'b0000, 8'h44, 2'd0, 1'b0);
    // Pointer wrap: grant 3, then 4'b1001 -> 0 wins, then 3
    tbl[15] = mk(4'b1000, 8'h1B, 2'd0, 4'b0000, 8'h44, 2'd0, 1'b1);
    tbl[16] = mk(4'b1000, 8'h1B, 2'd0, 4'b1000, 8'h11, 2'd3, 1'b1);
    tbl[17] = mk(4'b1001, 8'h1B, 2'd0, 4'b0000, 8'h11, 2'd3, 1'b0);
    tbl[18] = mk(4'b1001, 8'h1B, 2'd3, 4'b0000, 8'h11, 2'd3, 1'b1);
    tbl[19] = mk(4'b1001, 8'h1B, 2'd3, 4'b0001, 8'h44, 2'd0, 1'b1);
    tbl[20] = mk(4'b1000, 8'h1B, 2'd3, 4'b0000, 8'h44, 2'd0, 1'b0);
    tbl[21] = mk(4'b1000, 8'h1B, 2'd0, 4'b0000, 8'h44, 2'd0, 1'b1);
    tbl[22] = mk(4'b1000, 8'h1B, 2'd0, 4'b1000, 8'h11, 2'd3, 1'b1);
    tbl[23] = mk(4'b0000, 8'h1B, 2'd0, 4'b0000, 8'h11, 2'd3, 1'b0);
    // Single request, requester 2 reading register 2
    tbl[24] = mk(4'b0100, 8'h20, 2'd2, 4'b0000, 8'h11, 2'd3, 1'b1);
    tbl[25] = mk(4'b0100, 8'h20, 2'd2, 4'b0100, 8'h33, 2'd2, 1'b1);
    tbl[26] = mk(4'b0000, 8'h20, 2'd2, 4'b0000, 8'h33, 2'd2, 1'b0);
    // Address changed during SEL is ignored
    tbl[27] = mk(4'b0001, 8'h00, 2'd0, 4'b0000, 8'h33, 2'd2, 1'b1);
    tbl[28] = mk(4'b0001, 8'h03, 2'd0, 4'b0001, 8'h11, 2'd0, 1'b1);
    tbl[29] = mk(4'b0000, 8'h03, 2'd0, 4'b0000, 8'h11, 2'd0, 1'b0);
    // Early drop of requester 1 in SEL still acknowledged, never re-granted
    tbl[30] = mk(4'b0010, 8'h0C, 2'd3, 4'b0000, 8'h11, 2'd0, 1'b1);
    tbl[31] = mk(4'b0000, 8'h0C, 2'd3, 4'b0010, 8'h44, 2'd1, 1'b1);
    tbl[32] = mk(4'b0000, 8'h0C, 2'd3, 4'b0000, 8'h44, 2'd1, 1'b0);
    tbl[33] = mk(4'b0000, 8'h0C, 2'd3, 4'b0000, 8'h44, 2'd1, 1'b0);
    // Enter SEL ahead of the mid-transaction reset
    tbl[34] = mk(4'b0010, 8'h04, 2'd1, 4'b0000, 8'h44, 2'd1, 1'b1);

    inRST = 1'b0;
    iREQ  = 4'd0;
    iADDR = 8'd0;
    repeat (2) @(posedge iCLK);
    #1;
    check("reset_values", 2'd0, 4'd0, 8'h00, 2'd0, 1'b0);
    inRST = 1'b1;

    for (int i = 0; i < 35; i++) begin
      iREQ  = tbl[i].req;
      iADDR = tbl[i].addr;
      @(posedge iCLK);
      #1;
      check($sformatf("table[%0d]", i), tbl[i].sel, tbl[i].ack, tbl[i].data, tbl[i].id, tbl[i].busy);
    end

    // Asynchronous reset while in SEL with requester 1 still asking
    inRST = 1'b0;
    #1;
    check("async_reset_mid_sel", 2'd0, 4'd0, 8'h00, 2'd0, 1'b0);
    @(posedge iCLK);
    #1;
    check("reset_held", 2'd0, 4'd0, 8'h00, 2'd0, 1'b0);
    inRST = 1'b1;
    @(posedge iCLK);
    #1;
    check("post_reset_sel", 2'd1, 4'd0, 8'h00, 2'd0, 1'b1);
    @(posedge iCLK);
    #1;
    check("post_reset_ack", 2'd1, 4'b0010, 8'h22, 2'd1, 1'b1);
    iREQ = 4'd0;
    @(posedge iCLK);
    #1;
    check("post_reset_idle", 2'd1, 4'd0, 8'h22, 2'd1, 1'b0);

    // Random traffic against the reference model
    inRST = 1'b0;
    @(posedge iCLK);
    m_reset();
    #1;
    inRST = 1'b1;
    for (int n = 0; n < 800; n++) begin
      iREQ  = 4'($urandom_range(0, 15));
      iADDR = 8'($urandom_range(0, 255));
      inRST = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      @(posedge iCLK);
      m_edge(iREQ, iADDR, inRST);
      #1;
      check("random", m_sel, m_ack, m_data, m_id, (m_phase != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
